// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer, mid-bit sampling,
// and a show-ahead RX FIFO that raises framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] baud_div_i,
  input  logic        rx_en_i,
  input  logic        rx_bit_i,
  input  logic        rx_re_i,
  output logic [7:0]  dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // The synchronizer and edge detector reset to the idle line level, so a
  // reset does not look like a start edge.
  logic rx_meta_reg;
  logic rx_s_reg;
  logic rx_prev_reg;
  logic fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_bit_i;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  assign fall = rx_prev_reg & ~rx_s_reg;

  logic [15:0] div;
  logic [15:0] half;

  assign div  = (baud_div_i < 16'd4) ? 16'd4 : baud_div_i;
  assign half = {1'b0, div[15:1]};

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] limit_reg, limit_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  data_reg, data_next;
  logic        done_reg, done_next;
  logic        stop_ok_reg, stop_ok_next;
  logic        expire;

  // The limit is latched only on reload, so a divisor change mid-frame
  // waits for the next bit boundary.
  assign expire = (cnt_reg == limit_reg - 16'd1);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    limit_next   = limit_reg;
    bit_idx_next = bit_idx_reg;
    data_next    = data_reg;
    done_next    = 1'b0;
    stop_ok_next = stop_ok_reg;

    if (state_reg != IDLE) begin
      cnt_next = expire ? 16'd0 : cnt_reg + 16'd1;
    end

    case (state_reg)
      IDLE: begin
        if (rx_en_i && fall) begin
          state_next = START;
          cnt_next   = 16'd0;
          limit_next = half;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s_reg) begin
            state_next   = DATA;
            limit_next   = div;
            bit_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          data_next[bit_idx_reg] = rx_s_reg;
          bit_idx_next           = bit_idx_reg + 3'd1;
          limit_next             = div;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        // Leave at mid-stop so a start bit directly behind it is still seen.
        if (expire) begin
          done_next    = 1'b1;
          stop_ok_next = rx_s_reg;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (!rx_en_i) begin
      state_next   = IDLE;
      cnt_next     = 16'd0;
      bit_idx_next = 3'd0;
      done_next    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      cnt_reg     <= 16'd0;
      limit_reg   <= 16'd0;
      bit_idx_reg <= 3'd0;
      data_reg    <= 8'd0;
      done_reg    <= 1'b0;
      stop_ok_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      limit_reg   <= limit_next;
      bit_idx_reg <= bit_idx_next;
      data_reg    <= data_next;
      done_reg    <= done_next;
      stop_ok_reg <= stop_ok_next;
    end
  end

  // RX FIFO: the extra pointer MSB tells full from empty.
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        push;
  logic        pop;
  logic        frame_err_next;
  logic        overrun_next;

  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign dout_o  = empty_o ? 8'd0 : mem[rd_ptr_reg[AW-1:0]];

  // A pop in the same cycle frees the slot a completed byte needs.
  assign pop            = rx_re_i & ~empty_o;
  assign push           = done_reg & stop_ok_reg & (~full_o | pop);
  assign overrun_next   = done_reg & stop_ok_reg & full_o & ~pop;
  assign frame_err_next = done_reg & ~stop_ok_reg;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= data_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      frame_err_o <= frame_err_next;
      overrun_o   <= overrun_next;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven bit by bit, a queue models the
// FIFO contents, and a monitor pops and compares bytes and counts flag pulses.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DEPTH = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] baud_div_i;
  logic        rx_en_i;
  logic        rx_bit_i;
  logic        rx_re_i;
  logic [7:0]  dout_o;
  logic        full_o;
  logic        empty_o;
  logic        frame_err_o;
  logic        overrun_o;

  uart_rx #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .baud_div_i  (baud_div_i),
    .rx_en_i     (rx_en_i),
    .rx_bit_i    (rx_bit_i),
    .rx_re_i     (rx_re_i),
    .dout_o      (dout_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int  exp_fe = 0, exp_ovr = 0;
  int  got_fe = 0, got_ovr = 0;
  bit  auto_read = 1'b0;
  int  pop_at = -10;
  int  start_cyc = 0;
  int  empty_fall_cyc = -1000;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle(input int n);
    rx_bit_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  // Expected frame outcome is decided when the stop bit goes out, before
  // the receiver can have produced anything for it.
  task automatic send_frame(input logic [7:0] b, input logic [15:0] baud,
                            input bit stop_bit, input bit dis3, input bit pop_same);
    int d;
    d = (baud < 16'd4) ? 4 : int'(baud);
    @(negedge clk_i);
    baud_div_i = baud;
    rx_bit_i   = 1'b0;
    start_cyc  = cyc + 1;
    if (pop_same) pop_at = start_cyc + 2 + d / 2 + 9 * d + 1;
    repeat (d) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_bit_i = b[i];
      if (dis3 && i == 3) begin
        repeat (d / 2) @(negedge clk_i);
        rx_en_i = 1'b0;
        repeat (d - d / 2) @(negedge clk_i);
      end else begin
        repeat (d) @(negedge clk_i);
      end
    end
    rx_bit_i = stop_bit;
    if (!dis3) begin
      if (!stop_bit) exp_fe++;
      else if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(b);
      else exp_ovr++;
    end
    $display("sent 0x%02h div=%0d stop=%0d dis=%0d pop_same=%0d", b, d, stop_bit, dis3, pop_same);
    repeat (d) @(negedge clk_i);
  endtask

  task automatic check_latency(input int req);
    int lat;
    lat = empty_fall_cyc - start_cyc;
    checks++;
    if (lat < req - 1 || lat > req + 1) begin
      errors++;
      $display("FAIL latency: got %0d cycles, expected %0d +/-1", lat, req);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty_o) && n < 600) begin
      @(negedge clk_i);
      n++;
    end
    repeat (4) @(negedge clk_i);
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_empty"}, int'(empty_o), 1);
    check({name, "_frame_errs"}, got_fe, exp_fe);
    check({name, "_overruns"}, got_ovr, exp_ovr);
  endtask

  // Monitor: pops whenever reading is enabled (or at one requested cycle),
  // comparing the head byte against the model queue.
  initial begin
    bit pop;
    bit prev_empty;
    prev_empty = 1'b1;
    rx_re_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_ni !== 1'b1) begin
        rx_re_i    = 1'b0;
        prev_empty = 1'b1;
      end else begin
        if (prev_empty && !empty_o) empty_fall_cyc = cyc;
        prev_empty = empty_o;
        if (frame_err_o) got_fe++;
        if (overrun_o) got_ovr++;
        if (frame_err_o || overrun_o) check("flags_exclusive", int'(frame_err_o & overrun_o), 0);
        pop = !empty_o && (auto_read || pop_at == cyc + 1);
        if (pop) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_byte: got unexpected 0x%02h, expected no byte", dout_o);
          end else begin
            $display("read 0x%02h (expected 0x%02h)", dout_o, exp_q[0]);
            check("rx_byte", int'(dout_o), int'(exp_q[0]));
            void'(exp_q.pop_front());
          end
          rx_re_i = 1'b1;
        end else begin
          rx_re_i = (auto_read && empty_o && $urandom_range(0, 3) == 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [15:0] baud;
    int          d;
    logic [7:0]  t1 [4];
    t1[0] = 8'hA5; t1[1] = 8'h00; t1[2] = 8'hFF; t1[3] = 8'h3C;

    rst_ni = 1'b0; rx_en_i = 1'b0; rx_bit_i = 1'b1; baud_div_i = 16'd16;
    repeat (3) @(negedge clk_i);
    check("reset_empty", int'(empty_o), 1);
    check("reset_full", int'(full_o), 0);
    check("reset_dout", int'(dout_o), 0);
    check("reset_ferr", int'(frame_err_o), 0);
    check("reset_ovr", int'(overrun_o), 0);
    rst_ni = 1'b1;
    rx_en_i = 1'b1;
    auto_read = 1'b1;
    idle(5);

    // Basic frames with latency measurement.
    for (int i = 0; i < 4; i++) begin
      send_frame(t1[i], 16'd16, 1'b1, 1'b0, 1'b0);
      idle(40);
      check_latency(2 + 8 + 9 * 16 + 1);
    end
    drain("basic");

    // Framing error followed by a stuck-low line.
    send_frame(8'hA5, 16'd16, 1'b0, 1'b0, 1'b0);
    repeat (100) @(negedge clk_i);
    idle(80);
    drain("frame_err");

    // Short glitch is a false start.
    @(negedge clk_i);
    rx_bit_i = 1'b0;
    repeat (4) @(negedge clk_i);
    idle(80);
    drain("glitch");

    // Overrun with no reads.
    auto_read = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send_frame(8'(i), 16'd16, 1'b1, 1'b0, 1'b0);
      idle(20);
      check("fill_full", int'(full_o), int'(exp_q.size() == DEPTH));
    end
    send_frame(8'h20, 16'd16, 1'b1, 1'b0, 1'b0);
    idle(20);
    check("overrun_count", got_ovr, exp_ovr);
    check("overrun_full", int'(full_o), 1);
    auto_read = 1'b1;
    drain("overrun");

    // Same-cycle pop while full: no overrun, 0x20 lands last.
    auto_read = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send_frame(8'(i), 16'd16, 1'b1, 1'b0, 1'b0);
      idle(20);
    end
    send_frame(8'h20, 16'd16, 1'b1, 1'b0, 1'b1);
    idle(20);
    check("popfull_overruns", got_ovr, exp_ovr);
    check("popfull_full", int'(full_o), 1);
    auto_read = 1'b1;
    drain("popfull");

    // Disable during data bit 3, then a clean frame.
    send_frame(8'h77, 16'd16, 1'b1, 1'b1, 1'b0);
    idle(40);
    rx_en_i = 1'b1;
    idle(20);
    send_frame(8'h5A, 16'd16, 1'b1, 1'b0, 1'b0);
    idle(40);
    drain("disable");

    // Asynchronous reset mid-frame with bytes queued.
    auto_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'(8'h11 * (i + 1)), 16'd16, 1'b1, 1'b0, 1'b0);
      idle(20);
    end
    check("queued_nonempty", int'(empty_o), 0);
    @(negedge clk_i);
    rx_bit_i = 1'b0;
    repeat (50) @(negedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    check("arst_empty", int'(empty_o), 1);
    check("arst_full", int'(full_o), 0);
    check("arst_dout", int'(dout_o), 0);
    check("arst_flags", int'(frame_err_o | overrun_o), 0);
    exp_q.delete();
    rx_bit_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    auto_read = 1'b1;
    idle(5);
    send_frame(8'h81, 16'd4, 1'b1, 1'b0, 1'b0);
    idle(12);
    check_latency(2 + 2 + 9 * 4 + 1);
    drain("after_reset");

    // Randomized frames, divisors (including sub-minimum values) and stops.
    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom);
      baud = 16'($urandom_range(1, 20));
      d    = (baud < 16'd4) ? 4 : int'(baud);
      send_frame(b, baud, ($urandom_range(0, 7) != 0), 1'b0, 1'b0);
      idle(2 * d + int'($urandom_range(2, 10)));
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that pairs with the UART transmitter in the peripheral block. Either the transmitter's tx_bit_o (loopback) or the external RX pin drives its input.
- Oversamples the line with the same baud_div_i divisor the transmitter uses and recovers 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Completed bytes are pushed into a show-ahead RX FIFO that the UART register interface reads.
- Flags framing errors and overruns.

Parameters:
- DEPTH, 32, RX FIFO entries. Must be a power of two, at least 2.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- baud_div_i  in  16  clock cycles per bit. Values below 4 are treated as 4.
- rx_en_i  in  1  receiver enable.
- rx_bit_i  in  1  serial input; asynchronous to clk_i; idles high.
- rx_re_i  in  1  FIFO read strobe; pops the head entry.
- dout_o  out  8  FIFO head byte; valid while empty_o=0.
- full_o  out  1  FIFO full.
- empty_o  out  1  FIFO empty.
- frame_err_o  out  1  one-cycle pulse: received stop bit was 0.
- overrun_o  out  1  one-cycle pulse: a valid byte was dropped because the FIFO was full.

Behaviour:
Reset:
- Reset is asynchronous, active-low.
- Clears the FIFO: empty_o=1, full_o=0.
- Sets dout_o=0 (storage is not read while empty; the output is gated to 0).
- Sets frame_err_o=0 and overrun_o=0.
- Sets state to IDLE and clears all counters.
- Presets both synchronizer flops and the edge-detect register to 1.

Input synchronizer:
- rx_bit_i passes through two flops to form rx_s.
- A prev register holds the previous rx_s.
- A falling edge is prev=1 and rx_s=0.

Divisor:
- div = max(baud_div_i, 4).
- half = div>>1.
- The bit counter is 16 bits wide and counts 0..limit-1.

State machine (all states advance on clk_i):
- IDLE: on a falling edge with rx_en_i=1, load the counter with limit=half and go to START.
- START: on counter expiry, sample rx_s.
  - rx_s=0: set limit=div, clear the bit index, go to DATA.
  - rx_s=1: false start; go to IDLE with no flags.
- DATA: on each expiry, shift rx_s into bit position bit_idx (LSB first).
  - After bit 7, go to STOP with limit=div.
- STOP: on expiry, sample rx_s.
  - rx_s=1 and FIFO has room: push the byte.
  - rx_s=1 and FIFO full (after any same-cycle pop): drop the byte and pulse overrun_o.
  - rx_s=0: drop the byte and pulse frame_err_o.
  - In all cases, return to IDLE the next cycle.
  - The return happens at mid-stop bit, so a start bit immediately following is caught.

Stuck-low line: after a frame error with the line held low, no new frame starts until a genuine 1→0 edge occurs.

Receiver disable:
- rx_en_i=0 forces IDLE and clears the counter and bit index.
- A partial frame is discarded silently.
- FIFO contents are kept, and reads remain functional.

Baud divisor changes: a change to baud_div_i mid-frame takes effect at the next counter reload.

FIFO:
- Pointers are $clog2(DEPTH)+1 bits wide; wrap-around uses the MSB.
- full_o: MSBs differ and the low bits are equal.
- empty_o: pointers are equal.
- dout_o is the head entry, combinational.
- A pop occurs when rx_re_i=1 and empty_o=0. rx_re_i while empty is ignored.

Simultaneous push and pop:
- When full: both are accepted, the count stays the same, and there is no overrun.
- When empty: the pop is ignored and the push is accepted.

Latency:
- A byte becomes visible (empty_o falls) exactly 2 + half + 9*div + 1 cycles after the first clk_i edge that samples rx_bit_i low.
- The permitted tolerance is ±1 cycle, to absorb sampling alignment.

Flags: frame_err_o and overrun_o are registered, one cycle wide, and never asserted together.

Test Plan:
1. Loopback from the transmitter, div=16, rx_en_i=1, sending 0xA5, 0x00, 0xFF, 0x3C. Required: the FIFO yields the same bytes in order; frame_err_o and overrun_o stay 0; empty_o falls within 155±1 cycles of the start edge.
2. Drive 0xA5 at div=16 with the stop bit forced to 0. Required: one frame_err_o pulse; empty_o stays 1. Then hold the line low for 100 cycles and release. Required: no further frame.
3. Glitch: a 4-cycle low pulse on rx_bit_i at div=16. Required: return to IDLE from START; no flags; FIFO empty.
4. Overrun: receive 33 bytes 0x00..0x20 with no reads, DEPTH=32. Required: full_o=1 after byte 0x1F; overrun_o pulses on the 33rd byte; the reads drain 0x00..0x1F exactly. Repeat with rx_re_i pulsed in the same cycle as the 33rd push. Required: no overrun, and 0x20 ends up last.
5. Disable mid-frame: drop rx_en_i during data bit 3, then re-enable. Required: no byte and no flags. The next full frame, 0x5A, is received correctly.
6. Reset: assert rst_ni low asynchronously mid-frame with 3 bytes queued. Required: immediately empty_o=1, dout_o=0, flags 0. After release, a 0x81 frame at div=4 is received correctly.
